bank_writer: RTL and testbench

BANK_WRITER -- requirements
Module: bank_writer

---
 rtl/bank_writer_pkg.sv | 23 ++
 rtl/bank_writer_decode.sv | 41 ++++
 rtl/bank_writer.sv | 96 +++++++++
 tb/tb_bank_writer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bank_writer_pkg.sv
// Shared types and geometry for the banked lattice writer.
// A logical address is {row, bank}; banks are selected one-hot.
package bank_writer_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned ROW_W  = 11;
  localparam int unsigned BANK_W = 3;
  localparam int unsigned NBANKS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [NBANKS-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
    logic [NBANKS-1:0] oh;
    oh       = '0;
    oh[bank] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bank_writer_decode.sv
// Registered address decode: turns an accepted word into a one-hot bank
// write with shared row address and data, one cycle after the transfer.
module bank_writer_decode
  import bank_writer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xfer,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [NBANKS-1:0] bank_we,
  output logic [ROW_W-1:0]  bank_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic [NBANKS-1:0] we_q;
  logic [ROW_W-1:0]  row_q;
  logic [DATA_W-1:0] data_q;

  // Row and data hold their last values between writes; only the enables drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q   <= '0;
      row_q  <= '0;
      data_q <= '0;
    end else begin
      we_q <= xfer ? bank_onehot(addr[BANK_W-1:0]) : '0;
      if (xfer) begin
        row_q  <= addr[ADDR_W-1:BANK_W];
        data_q <= din;
      end
    end
  end

  assign bank_we   = we_q;
  assign bank_addr = row_q;
  assign wr_data   = data_q;

endmodule

// File: rtl/bank_writer.sv
// Sweep controller writing a stream of node values across 8 banks.
// Define ADDR_DESCEND_EN to walk addresses downwards instead of upwards.
module bank_writer
  import bank_writer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [NBANKS-1:0] bank_we,
  output logic [ROW_W-1:0]  bank_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              xfer;

  assign xfer = (state_q == RUN) && din_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d = RUN;
            addr_d  = base_addr;
            rem_d   = count;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (xfer) begin
`ifdef ADDR_DESCEND_EN
          addr_d = addr_q - AddrOne;
`else
          addr_d = addr_q + AddrOne;
`endif
          rem_d  = rem_q - AddrOne;
          if (rem_q == AddrOne) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Status is decoded straight from state so reset clears it without a clock.
  assign din_ready = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  bank_writer_decode #(
    .DATA_W(DATA_W)
  ) u_decode (
    .clk      (clk),
    .reset    (reset),
    .xfer     (xfer),
    .addr     (addr_q),
    .din      (din),
    .bank_we  (bank_we),
    .bank_addr(bank_addr),
    .wr_data  (wr_data)
  );

endmodule

// File: tb/tb_bank_writer.sv
// Directed, table-driven bench for bank_writer plus hand-written reset cases.
module tb_bank_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] base_addr;
  logic [13:0] count;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  bank_we;
  logic [10:0] bank_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  bank_writer #(
    .DATA_W(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .bank_we  (bank_we),
    .bank_addr(bank_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied for one cycle; expected outputs are those after the next edge.
  typedef struct {
    logic        st;
    logic [13:0] base;
    logic [13:0] cnt;
    logic        vld;
    logic [31:0] d;
    logic [7:0]  we;
    logic [10:0] addr;
    logic [31:0] data;
    logic        dn;
    logic        bsy;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [13:0] base, input logic [13:0] cnt,
                              input logic vld, input logic [31:0] d, input logic [7:0] we,
                              input logic [10:0] addr, input logic [31:0] data, input logic dn,
                              input logic bsy, input logic rdy);
    vec_t v;
    v.st = st; v.base = base; v.cnt = cnt; v.vld = vld; v.d = d;
    v.we = we; v.addr = addr; v.data = data; v.dn = dn; v.bsy = bsy; v.rdy = rdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] we, input logic [10:0] addr,
                           input logic [31:0] data, input logic dn, input logic bsy,
                           input logic rdy);
    check({tag, ".bank_we"}, 32'(bank_we), 32'(we));
    check({tag, ".bank_addr"}, 32'(bank_addr), 32'(addr));
    check({tag, ".wr_data"}, wr_data, data);
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".din_ready"}, 32'(din_ready), 32'(rdy));
  endtask

  task automatic drive(input logic st, input logic [13:0] base, input logic [13:0] cnt,
                       input logic vld, input logic [31:0] d);
    start = st; base_addr = base; count = cnt; din_valid = vld; din = d;
  endtask

  initial begin
    int writes;
    int dones;
    drive(1'b0, 14'h0, 14'h0, 1'b0, 32'h0);
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_all("reset", 8'h00, 11'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

`ifndef ADDR_DESCEND_EN
    // Basic sweep: base 5, count 3
    vecs.push_back(mk(1, 14'h0005, 3, 0, 32'h0,  8'h00, 11'h000, 32'h0,  0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hA1, 8'h20, 11'h000, 32'hA1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hA2, 8'h40, 11'h000, 32'hA2, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hA3, 8'h80, 11'h000, 32'hA3, 1, 1, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'h0,  8'h00, 11'h000, 32'hA3, 0, 0, 0));
    // Row crossing: base 7, count 2
    vecs.push_back(mk(1, 14'h0007, 2, 0, 32'h0,  8'h00, 11'h000, 32'hA3, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hB1, 8'h80, 11'h000, 32'hB1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hB2, 8'h01, 11'h001, 32'hB2, 1, 1, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'h0,  8'h00, 11'h001, 32'hB2, 0, 0, 0));
    // Stall: base 0x10, count 4, valid 1,0,0,1,1,1
    vecs.push_back(mk(1, 14'h0010, 4, 0, 32'h0,  8'h00, 11'h001, 32'hB2, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hC1, 8'h01, 11'h002, 32'hC1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'hDEAD, 8'h00, 11'h002, 32'hC1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'hBEEF, 8'h00, 11'h002, 32'hC1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hC2, 8'h02, 11'h002, 32'hC2, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hC3, 8'h04, 11'h002, 32'hC3, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hC4, 8'h08, 11'h002, 32'hC4, 1, 1, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'h0,  8'h00, 11'h002, 32'hC4, 0, 0, 0));
    // count 0: done next cycle, no write even with din_valid high
    vecs.push_back(mk(1, 14'h0123, 0, 1, 32'h55, 8'h00, 11'h002, 32'hC4, 1, 1, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'h0,  8'h00, 11'h002, 32'hC4, 0, 0, 0));
    // Address wrap at 0x3FFF
    vecs.push_back(mk(1, 14'h3FFF, 2, 0, 32'h0,  8'h00, 11'h002, 32'hC4, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hD1, 8'h80, 11'h7FF, 32'hD1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hD2, 8'h01, 11'h000, 32'hD2, 1, 1, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'h0,  8'h00, 11'h000, 32'hD2, 0, 0, 0));
    // start while busy (RUN and DONE) is ignored
    vecs.push_back(mk(1, 14'h0020, 3, 0, 32'h0,  8'h00, 11'h000, 32'hD2, 0, 1, 1));
    vecs.push_back(mk(1, 14'h0100, 5, 1, 32'hE1, 8'h01, 11'h004, 32'hE1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hE2, 8'h02, 11'h004, 32'hE2, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hE3, 8'h04, 11'h004, 32'hE3, 1, 1, 0));
    vecs.push_back(mk(1, 14'h0040, 1, 1, 32'hE4, 8'h00, 11'h004, 32'hE3, 0, 0, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hE5, 8'h00, 11'h004, 32'hE3, 0, 0, 0));
`else
    vecs.push_back(mk(1, 14'h0005, 3, 0, 32'h0,  8'h00, 11'h000, 32'h0,  0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hA1, 8'h20, 11'h000, 32'hA1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hA2, 8'h10, 11'h000, 32'hA2, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hA3, 8'h08, 11'h000, 32'hA3, 1, 1, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'h0,  8'h00, 11'h000, 32'hA3, 0, 0, 0));
    vecs.push_back(mk(1, 14'h3FFF, 2, 0, 32'h0,  8'h00, 11'h000, 32'hA3, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hD1, 8'h80, 11'h7FF, 32'hD1, 0, 1, 1));
    vecs.push_back(mk(0, 14'h0000, 0, 1, 32'hD2, 8'h40, 11'h7FF, 32'hD2, 1, 1, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'h0,  8'h00, 11'h7FF, 32'hD2, 0, 0, 0));
    vecs.push_back(mk(1, 14'h0123, 0, 1, 32'h55, 8'h00, 11'h7FF, 32'hD2, 1, 1, 0));
    vecs.push_back(mk(0, 14'h0000, 0, 0, 32'h0,  8'h00, 11'h7FF, 32'hD2, 0, 0, 0));
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].base, vecs[i].cnt, vecs[i].vld, vecs[i].d);
      @(posedge clk);
      #1 check_all($sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].dn,
                   vecs[i].bsy, vecs[i].rdy);
    end

    // Reset after 2 of 5 transfers: outputs clear without a clock edge.
    @(negedge clk); drive(1'b1, 14'h0030, 14'd5, 1'b0, 32'h0);
    @(negedge clk); drive(1'b0, 14'h0000, 14'd0, 1'b1, 32'hF1);
    @(negedge clk); drive(1'b0, 14'h0000, 14'd0, 1'b1, 32'hF2);
    @(negedge clk);
    #2 reset = 1'b1;
    din_valid = 1'b0;
    #1 check_all("midrst", 8'h00, 11'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    writes = 0;
    dones  = 0;
    din_valid = 1'b1;
    din = 32'hF3;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bank_we != 8'h00) writes++;
      if (done) dones++;
    end
    check("post_rst.writes", 32'(writes), 32'd0);
    check("post_rst.dones", 32'(dones), 32'd0);

    @(negedge clk); drive(1'b1, 14'h0009, 14'd1, 1'b0, 32'h0);
    @(negedge clk); drive(1'b0, 14'h0000, 14'd0, 1'b1, 32'h77);
    @(posedge clk);
    #1 check_all("restart", 8'h02, 11'h001, 32'h77, 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive(1'b0, 14'h0000, 14'd0, 1'b0, 32'h0);
    @(posedge clk);
    #1 check_all("restart_end", 8'h00, 11'h001, 32'h77, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
